zx_capture_sequencer: RTL
=========================

// Module: zx_capture_sequencer
// PURPOSE
//  Frame-capture sequencer and sync meter for the ZX RGBI->DCMI bridge, clocked by ZX_PIX_CLK.
//  Arms on a start request and opens the DCMI gate (cap_enable) on a frame boundary.
//  Passes a requested number of whole frames, then closes the gate on the next frame boundary.
//  When sync_meter is set, it also measures line length (pixel clocks) and lines per frame.
//  Sits between the SPI control register and the DCMI output gating.
// PARAMETERS
//  SYNC_ACT_LOW  1   1: ZX_VS/ZX_HS are active-low; 0: active-high
//  LLEN_W        12  width of line-length counter/result
//  LCNT_W        10  width of line-count counter/result
// PORTS
//  ZX_PIX_CLK   in   1       sole clock, all logic on rising edge
//  reset        in   1       synchronous, active-high
//  ZX_VS        in   1       vertical sync, synchronous to ZX_PIX_CLK
//  ZX_HS        in   1       horizontal sync, synchronous to ZX_PIX_CLK
//  start        in   1       capture request (level sampled per cycle)
//  abort        in   1       stop capture immediately
//  frames_req   in   8       frames to capture; 0 = continuous; latched on accepted start
//  sync_meter   in   1       enable sync measurement
//  cap_enable   out  1       DCMI gate (drives DCMI enable)
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse when capture completes normally
//  frames_done  out  8       frames passed in current/last capture
//  line_len     out  LLEN_W  pixel clocks between consecutive HS leading edges
//  frame_lines  out  LCNT_W  HS leading edges between consecutive VS leading edges
//  meas_valid   out  1       line_len/frame_lines hold a complete measurement
//  meas_ovf     out  1       sticky: a measurement counter saturated
// BEHAVIOUR
//  Reset: state IDLE. All outputs are 0. Sync history registers are set to the inactive level.
//  Edge detect: vs_start = VS active now AND inactive previous cycle (registered history); hs_start likewise.
//  FSM states: IDLE, ARM, CAPT, DONE.
//   IDLE -> ARM when start=1 and abort=0. frames_req is latched and frames_done is cleared.
//   ARM -> CAPT on vs_start. cap_enable=1 from the following cycle.
//   CAPT: each vs_start increments frames_done (wraps at 255 in continuous mode).
//   CAPT -> DONE on the vs_start where frames_done+1 == latched req (req!=0). cap_enable=0 next cycle.
//   DONE -> IDLE after exactly one cycle. done=1 during that cycle.
//   Any state -> IDLE on abort; abort has priority over every other event.
//    After abort, cap_enable=0 next cycle, done is not pulsed, and frames_done is held.
//   start is ignored when state != IDLE.
//  cap_enable is a registered output equal to (state==CAPT). It only changes on a vs_start cycle or on abort.
//  Measurement, when sync_meter=1:
//   hs_cnt clears on hs_start and otherwise increments, saturating at all-ones.
//   On hs_start, line_len <= hs_cnt+1 (saturated). A line period of P clocks therefore gives line_len=P.
//   ln_cnt counts hs_start. An hs_start coincident with vs_start counts into the new frame.
//   On vs_start, frame_lines <= ln_cnt, and ln_cnt <= (hs_start?1:0).
//   meas_valid sets on the 2nd vs_start after sync_meter rises (the first complete frame).
//   meas_ovf sets if either counter saturates. It clears only on reset or sync_meter=0.
//  When sync_meter=0: hs_cnt/ln_cnt held at 0; meas_valid and meas_ovf are 0.
//   line_len and frame_lines hold their last values.
//  Measurement runs independently of the FSM state.
//  Reset mid-capture: returns to IDLE with all outputs 0 on the next edge.
// TESTING
//  T1 line=16 clk, frame=10 lines, frames_req=2, start pulse -> cap_enable rises 1 clk after 1st vs_start.
//     cap_enable falls 1 clk after 3rd vs_start; done pulses once; frames_done=2.
//  T2 sync_meter=1 with the T1 timing -> after 2 VS leading edges, line_len=16, frame_lines=10, meas_valid=1.
//  T3 frames_req=0 -> capture runs 300 frames, frames_done wraps to 44.
//     abort -> cap_enable=0 next clk, no done pulse, busy=0.
//  T4 start=abort=1 in IDLE -> stays IDLE. start during CAPT -> frames_req is not re-latched.
//  T5 HS held inactive 5000 clk with LLEN_W=12 -> line_len=4095, meas_ovf=1.
//     sync_meter=0 -> meas_ovf=0 and meas_valid=0.
//  T6 reset asserted in CAPT mid-frame -> next clk: cap_enable=0, busy=0, frames_done=0, line_len=0.

Source files
------------

// File: rtl/zx_capture_sequencer_if.sv
// Control/status bundle between the SPI register block and the ZX capture sequencer.
// The sequencer uses the slave modport; the controlling side uses master.
interface zx_capture_sequencer_if #(
  parameter int LLEN_W = 12,
  parameter int LCNT_W = 10
);
  logic              ZX_VS;
  logic              ZX_HS;
  logic              start;
  logic              abort;
  logic [7:0]        frames_req;
  logic              sync_meter;
  logic              cap_enable;
  logic              busy;
  logic              done;
  logic [7:0]        frames_done;
  logic [LLEN_W-1:0] line_len;
  logic [LCNT_W-1:0] frame_lines;
  logic              meas_valid;
  logic              meas_ovf;

  modport master (
    output ZX_VS, ZX_HS, start, abort, frames_req, sync_meter,
    input  cap_enable, busy, done, frames_done, line_len, frame_lines, meas_valid, meas_ovf
  );

  modport slave (
    input  ZX_VS, ZX_HS, start, abort, frames_req, sync_meter,
    output cap_enable, busy, done, frames_done, line_len, frame_lines, meas_valid, meas_ovf
  );
endinterface

// File: rtl/zx_capture_sequencer.sv
// Frame-capture sequencer and sync meter for the ZX RGBI->DCMI bridge.
// Opens/closes the DCMI gate on frame boundaries and measures line/frame timing.
module zx_capture_sequencer #(
  parameter bit SYNC_ACT_LOW = 1'b1,
  parameter int LLEN_W       = 12,
  parameter int LCNT_W       = 10
) (
  input logic                  ZX_PIX_CLK,
  input logic                  reset,
  zx_capture_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, CAPT, DONE} state_t;

  localparam logic [LLEN_W-1:0] LLEN_MAX = '1;
  localparam logic [LCNT_W-1:0] LCNT_MAX = '1;

  state_t            r_state;
  state_t            w_next;
  logic              r_vs_hist;
  logic              r_hs_hist;
  logic              r_cap_enable;
  logic [7:0]        r_req;
  logic [7:0]        r_frames_done;
  logic [LLEN_W-1:0] r_hs_cnt;
  logic [LLEN_W-1:0] r_line_len;
  logic [LCNT_W-1:0] r_ln_cnt;
  logic [LCNT_W-1:0] r_frame_lines;
  logic              r_vs_seen;
  logic              r_meas_valid;
  logic              r_meas_ovf;
  logic              w_vs_start;
  logic              w_hs_start;
  logic              w_last_frame;
  logic              w_hs_sat;
  logic              w_ln_sat;
  logic              w_busy;
  logic              w_done;

  // History holds raw pin levels; XOR with the polarity gives "active".
  always_ff @(posedge ZX_PIX_CLK) begin
    if (reset) begin
      r_vs_hist <= SYNC_ACT_LOW;
      r_hs_hist <= SYNC_ACT_LOW;
    end else begin
      r_vs_hist <= bus.ZX_VS;
      r_hs_hist <= bus.ZX_HS;
    end
  end

  assign w_vs_start   = (bus.ZX_VS ^ SYNC_ACT_LOW) & ~(r_vs_hist ^ SYNC_ACT_LOW);
  assign w_hs_start   = (bus.ZX_HS ^ SYNC_ACT_LOW) & ~(r_hs_hist ^ SYNC_ACT_LOW);
  assign w_last_frame = (r_req != 8'd0) && ((r_frames_done + 8'd1) == r_req);

  always_ff @(posedge ZX_PIX_CLK) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.start) w_next = ARM;
        ARM:     if (w_vs_start) w_next = CAPT;
        CAPT:    if (w_vs_start && w_last_frame) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != IDLE);
    w_done = (r_state == DONE);
  end

  // Gate is a flop of the next state so it moves exactly one clock after the deciding edge.
  always_ff @(posedge ZX_PIX_CLK) begin
    if (reset) begin
      r_cap_enable  <= 1'b0;
      r_req         <= 8'd0;
      r_frames_done <= 8'd0;
    end else begin
      r_cap_enable <= (w_next == CAPT);
      if (!bus.abort) begin
        if (r_state == IDLE && bus.start) begin
          r_req         <= bus.frames_req;
          r_frames_done <= 8'd0;
        end else if (r_state == CAPT && w_vs_start) begin
          r_frames_done <= r_frames_done + 8'd1;
        end
      end
    end
  end

  assign w_hs_sat = (r_hs_cnt == LLEN_MAX);
  assign w_ln_sat = (r_ln_cnt == LCNT_MAX);

  // Meter runs regardless of capture state; an HS edge on the VS edge belongs to the new frame.
  always_ff @(posedge ZX_PIX_CLK) begin
    if (reset) begin
      r_hs_cnt      <= '0;
      r_line_len    <= '0;
      r_ln_cnt      <= '0;
      r_frame_lines <= '0;
      r_vs_seen     <= 1'b0;
      r_meas_valid  <= 1'b0;
      r_meas_ovf    <= 1'b0;
    end else if (!bus.sync_meter) begin
      r_hs_cnt     <= '0;
      r_ln_cnt     <= '0;
      r_vs_seen    <= 1'b0;
      r_meas_valid <= 1'b0;
      r_meas_ovf   <= 1'b0;
    end else begin
      if (w_hs_start) begin
        r_hs_cnt   <= '0;
        r_line_len <= w_hs_sat ? LLEN_MAX : (r_hs_cnt + LLEN_W'(1));
      end else if (!w_hs_sat) begin
        r_hs_cnt <= r_hs_cnt + LLEN_W'(1);
      end

      if (w_vs_start) begin
        r_frame_lines <= r_ln_cnt;
        r_ln_cnt      <= w_hs_start ? LCNT_W'(1) : '0;
        r_vs_seen     <= 1'b1;
        if (r_vs_seen) r_meas_valid <= 1'b1;
      end else if (w_hs_start && !w_ln_sat) begin
        r_ln_cnt <= r_ln_cnt + LCNT_W'(1);
      end

      if (w_hs_sat || w_ln_sat) r_meas_ovf <= 1'b1;
    end
  end

  assign bus.cap_enable  = r_cap_enable;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.frames_done = r_frames_done;
  assign bus.line_len    = r_line_len;
  assign bus.frame_lines = r_frame_lines;
  assign bus.meas_valid  = r_meas_valid;
  assign bus.meas_ovf    = r_meas_ovf;

endmodule
